// File: rtl/ddr4_cal_reset_sequencer.sv
// DDR4 EMIF calibration / SoC reset sequencer: requests recalibration, retries on
// timeout or failure, holds the SoC in reset for a settle period, then releases it.
module ddr4_cal_reset_sequencer #(
  parameter int SYNC_STAGES        = 2,
  parameter int REQ_PULSE_CYCLES   = 16,
  parameter int CAL_TIMEOUT_CYCLES = 50000000,
  parameter int MAX_RETRIES        = 3,
  parameter int SOC_HOLD_CYCLES    = 1024,
  parameter int HEARTBEAT_BITS     = 25,
  localparam int RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cal_success,
  input  logic               cal_fail,
  input  logic               reset_done,
  output logic               local_reset_req,
  output logic               soc_reset,
  output logic               error,
  output logic [RETRY_W-1:0] retry_count,
  output logic [3:0]         led
);

  localparam int TIMER_W = $clog2(CAL_TIMEOUT_CYCLES + 1);
  localparam int HOLD_W  = $clog2(SOC_HOLD_CYCLES + 1);
  localparam int REQ_W   = $clog2(REQ_PULSE_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT_DONE, S_WAIT_CAL, S_HOLD, S_RUN, S_FAIL
  } state_t;

  state_t state, next_state;

  logic [SYNC_STAGES-1:0] success_sync, fail_sync, done_sync;
  logic cal_success_s, cal_fail_s, reset_done_s;

  logic [TIMER_W-1:0]        timer, timer_next;
  logic [HOLD_W-1:0]         hold_cnt, hold_next;
  logic [REQ_W-1:0]          req_cnt, req_next;
  logic [RETRY_W-1:0]        retry_next;
  logic [HEARTBEAT_BITS-1:0] heartbeat;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      success_sync <= '0;
      fail_sync    <= '0;
      done_sync    <= '0;
    end else begin
      success_sync <= {success_sync[SYNC_STAGES-2:0], cal_success};
      fail_sync    <= {fail_sync[SYNC_STAGES-2:0], cal_fail};
      done_sync    <= {done_sync[SYNC_STAGES-2:0], reset_done};
    end
  end

  assign cal_success_s = success_sync[SYNC_STAGES-1];
  assign cal_fail_s    = fail_sync[SYNC_STAGES-1];
  assign reset_done_s  = done_sync[SYNC_STAGES-1];

  // NOTE: every always_comb output gets a default first, so no path infers a latch.
  always_comb begin
    next_state = state;
    timer_next = timer;
    hold_next  = hold_cnt;
    req_next   = req_cnt;
    retry_next = retry_count;
    unique case (state)
      S_IDLE: begin
        next_state = S_REQ;
        req_next   = '0;
      end
      S_REQ: begin
        if (req_cnt == REQ_W'(REQ_PULSE_CYCLES - 1)) begin
          next_state = S_WAIT_DONE;
          timer_next = '0;
        end else begin
          req_next = req_cnt + REQ_W'(1);
        end
      end
      S_WAIT_DONE, S_WAIT_CAL: begin
        if (state == S_WAIT_DONE && reset_done_s) begin
          next_state = S_WAIT_CAL;
          timer_next = '0;
        end else if (state == S_WAIT_CAL && cal_success_s) begin
          // Success outranks a simultaneous fail or timeout.
          next_state = S_HOLD;
          hold_next  = '0;
        end else if ((state == S_WAIT_CAL && cal_fail_s) ||
                     timer == TIMER_W'(CAL_TIMEOUT_CYCLES - 1)) begin
          if (retry_count < RETRY_W'(MAX_RETRIES)) begin
            retry_next = retry_count + RETRY_W'(1);
            next_state = S_REQ;
            req_next   = '0;
          end else begin
            next_state = S_FAIL;
          end
        end else begin
          timer_next = timer + TIMER_W'(1);
        end
      end
      S_HOLD: begin
        if (!cal_success_s) begin
          next_state = S_WAIT_CAL;
          timer_next = '0;
        end else if (hold_cnt == HOLD_W'(SOC_HOLD_CYCLES - 1)) begin
          next_state = S_RUN;
        end else begin
          hold_next = hold_cnt + HOLD_W'(1);
        end
      end
      S_RUN: begin
        if (!cal_success_s || cal_fail_s) begin
          next_state = S_REQ;
          req_next   = '0;
          retry_next = '0;
        end
      end
      S_FAIL: next_state = S_FAIL;
      default: next_state = S_IDLE;
    endcase
  end

  // Outputs are registered from next_state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_IDLE;
      timer           <= '0;
      hold_cnt        <= '0;
      req_cnt         <= '0;
      retry_count     <= '0;
      heartbeat       <= '0;
      local_reset_req <= 1'b0;
      soc_reset       <= 1'b1;
      error           <= 1'b0;
      led             <= '0;
    end else begin
      state           <= next_state;
      timer           <= timer_next;
      hold_cnt        <= hold_next;
      req_cnt         <= req_next;
      retry_count     <= retry_next;
      heartbeat       <= heartbeat + HEARTBEAT_BITS'(1);
      local_reset_req <= (next_state == S_REQ);
      soc_reset       <= (next_state != S_RUN);
      error           <= (next_state == S_FAIL);
      led[0]          <= (next_state == S_RUN) && heartbeat[HEARTBEAT_BITS-1];
      led[1]          <= cal_success_s;
      led[2]          <= (next_state == S_FAIL);
      led[3]          <= (next_state == S_REQ) || (next_state == S_WAIT_DONE) ||
                         (next_state == S_WAIT_CAL) || (next_state == S_HOLD);
    end
  end

endmodule

// File: tb/tb_ddr4_cal_reset_sequencer.sv
// Directed self-checking bench for ddr4_cal_reset_sequencer with small timing
// parameters so retries, timeouts and the hold period fit in a short run.
module tb_ddr4_cal_reset_sequencer;

  localparam int SYNC = 2;
  localparam int REQP = 4;
  localparam int TOUT = 20;
  localparam int MAXR = 2;
  localparam int HOLD = 8;
  localparam int HBB  = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       cal_success, cal_fail, reset_done;
  logic       local_reset_req, soc_reset, error;
  logic [1:0] retry_count;
  logic [3:0] led;

  int checks = 0;
  int errors = 0;

  ddr4_cal_reset_sequencer #(
    .SYNC_STAGES(SYNC), .REQ_PULSE_CYCLES(REQP), .CAL_TIMEOUT_CYCLES(TOUT),
    .MAX_RETRIES(MAXR), .SOC_HOLD_CYCLES(HOLD), .HEARTBEAT_BITS(HBB)
  ) dut (
    .clk(clk), .reset(reset), .cal_success(cal_success), .cal_fail(cal_fail),
    .reset_done(reset_done), .local_reset_req(local_reset_req),
    .soc_reset(soc_reset), .error(error), .retry_count(retry_count), .led(led)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_req"},   32'(local_reset_req), 32'd0);
    check({tag, "_soc"},   32'(soc_reset),       32'd1);
    check({tag, "_err"},   32'(error),           32'd0);
    check({tag, "_retry"}, 32'(retry_count),     32'd0);
    check({tag, "_led"},   32'(led),             32'd0);
  endtask

  task automatic wait_req_rise(input string tag, input int budget);
    int n = 0;
    while (local_reset_req !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(local_reset_req), 32'd1);
  endtask

  // Counts the cycles the request stays high, leaving the bench on the first low cycle.
  task automatic pulse_width(input string tag, input int exp);
    int w = 0;
    while (local_reset_req === 1'b1 && w < 40) begin
      w++;
      tick();
    end
    check(tag, 32'(w), 32'(exp));
  endtask

  task automatic wait_soc_low(input string tag, input int budget);
    int n = 0;
    while (soc_reset !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(soc_reset), 32'd0);
  endtask

  initial begin
    int rises, gap, last_rise, violations;
    logic prev_req, saw_hi, saw_lo, req_seen;

    reset = 1'b1; cal_success = 1'b0; cal_fail = 1'b0; reset_done = 1'b0;
    tick(3);
    check_reset_values("por");

    // 1: clean sequence, success raised while waiting for calibration
    reset_done = 1'b1;
    reset = 1'b0;
    wait_req_rise("t1_req_rise", 10);
    pulse_width("t1_req_width", REQP);
    tick(2);
    cal_success = 1'b1;
    req_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (local_reset_req) req_seen = 1'b1;
    end
    check("t1_soc_before", 32'(soc_reset), 32'd1);
    check("t1_busy_hold",  32'(led[3]),    32'd1);
    tick();
    check("t1_soc_run",    32'(soc_reset), 32'd0);
    check("t1_busy_run",   32'(led[3]),    32'd0);
    check("t1_led_cal",    32'(led[1]),    32'd1);
    check("t1_retry",      32'(retry_count), 32'd0);
    check("t1_no_req",     32'(req_seen),  32'd0);
    saw_hi = 1'b0; saw_lo = 1'b0;
    for (int i = 0; i < 32; i++) begin
      tick();
      if (led[0]) saw_hi = 1'b1; else saw_lo = 1'b0 | 1'b1;
    end
    check("t1_hb_hi", 32'(saw_hi), 32'd1);
    check("t1_hb_lo", 32'(saw_lo), 32'd1);

    // 3 + 5: fail on first attempt, success on the second, then lose cal in RUN
    reset = 1'b1; cal_success = 1'b0;
    tick();
    check_reset_values("t3_rst");
    reset = 1'b0;
    wait_req_rise("t3_req1", 10);
    pulse_width("t3_width1", REQP);
    tick(2);
    cal_fail = 1'b1;
    tick();
    cal_fail = 1'b0;
    wait_req_rise("t3_req2", 10);
    check("t3_retry_req", 32'(retry_count), 32'd1);
    pulse_width("t3_width2", REQP);
    tick(2);
    cal_success = 1'b1;
    wait_soc_low("t3_run", 20);
    check("t3_retry_run", 32'(retry_count), 32'd1);
    check("t3_err",       32'(error),       32'd0);
    tick(3);
    cal_success = 1'b0;
    tick(2);
    check("t5_soc_still_low", 32'(soc_reset), 32'd0);
    tick();
    check("t5_soc_high", 32'(soc_reset),       32'd1);
    check("t5_req",      32'(local_reset_req), 32'd1);
    check("t5_retry",    32'(retry_count),     32'd0);
    pulse_width("t5_width", REQP);
    cal_success = 1'b1;
    wait_soc_low("t5_rerun", 30);

    // 4: success and fail together -> success wins, no extra request
    reset = 1'b1; cal_success = 1'b0;
    tick();
    reset = 1'b0;
    wait_req_rise("t4_req", 10);
    pulse_width("t4_width", REQP);
    tick(2);
    cal_success = 1'b1; cal_fail = 1'b1;
    tick();
    cal_fail = 1'b0;
    req_seen = 1'b0;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (local_reset_req) req_seen = 1'b1;
    end
    check("t4_soc_before", 32'(soc_reset), 32'd1);
    tick();
    check("t4_soc_run", 32'(soc_reset), 32'd0);
    check("t4_no_req",  32'(req_seen),  32'd0);
    check("t4_retry",   32'(retry_count), 32'd0);

    // 2: no calibration result ever -> three attempts, then FAIL
    reset = 1'b1; cal_success = 1'b0;
    tick();
    reset = 1'b0;
    rises = 0; gap = 0; last_rise = 0; prev_req = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (local_reset_req && !prev_req) begin
        if (rises == 1) gap = i - last_rise;
        rises++;
        last_rise = i;
      end
      prev_req = local_reset_req;
    end
    check("t2_pulses", 32'(rises),       32'd3);
    check("t2_gap",    32'(gap),         32'(REQP + 1 + TOUT));
    check("t2_err",    32'(error),       32'd1);
    check("t2_led_err",32'(led[2]),      32'd1);
    check("t2_busy",   32'(led[3]),      32'd0);
    check("t2_retry",  32'(retry_count), 32'd2);
    violations = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (soc_reset !== 1'b1 || local_reset_req !== 1'b0) violations++;
    end
    check("t2_stay_fail", 32'(violations), 32'd0);
    check("t2_err_sticky", 32'(error), 32'd1);

    // 6: reset mid-pulse and mid-HOLD
    reset = 1'b1;
    tick();
    reset = 1'b0; cal_success = 1'b1;
    wait_req_rise("t6_req_a", 10);
    tick(2);
    reset = 1'b1;
    tick();
    check_reset_values("t6_midreq");
    tick();
    reset = 1'b0;
    wait_req_rise("t6_req_b", 10);
    pulse_width("t6_width_b", REQP);
    tick(4);
    check("t6_in_hold_busy", 32'(led[3]),    32'd1);
    check("t6_in_hold_soc",  32'(soc_reset), 32'd1);
    reset = 1'b1;
    tick();
    check_reset_values("t6_midhold");
    reset = 1'b0;
    wait_req_rise("t6_req_c", 10);
    pulse_width("t6_width_c", REQP);
    wait_soc_low("t6_run", 30);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
